// File: rtl/thresholding_cfg_loader.sv
// thresholding_cfg_loader: boot-time configuration master for the thresholding
// block. Writes a channel-major threshold stream through the target's cfg_*
// port, flags non-ascending thresholds and, when VERIFY=1, reads the whole
// table back and checks it against a checksum and the same ordering rule.
//
// Handshake: a threshold beat transfers on a rising clk edge where s_tvalid and
// s_tready are both 1; s_tready is registered, high only in LOAD, and
// s_tdata must be held stable while s_tvalid=1 and s_tready=0.
module thresholding_cfg_loader #(
  parameter int N      = 2,
  parameter int K      = 8,
  parameter int C      = 2,
  parameter int PE     = 2,
  parameter bit SIGNED = 1'b1,
  parameter bit VERIFY = 1'b1,
  localparam int CF    = C / PE,
  localparam int A_W   = $clog2(CF) + $clog2(PE) + N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s_tvalid,
  output logic           s_tready,
  input  logic [K-1:0]   s_tdata,
  output logic           cfg_en,
  output logic           cfg_we,
  output logic [A_W-1:0] cfg_a,
  output logic [K-1:0]   cfg_d,
  input  logic           cfg_rack,
  input  logic [K-1:0]   cfg_q,
  input  logic           start,
  output logic           done,
  output logic           err_order,
  output logic           err_chk,
  output logic [1:0]     state_dbg
);

  localparam int T_MAX = (1 << N) - 2;
  localparam int TOTAL = C * ((1 << N) - 1);
  localparam int CF_W  = $clog2(CF);
  localparam int PE_W  = $clog2(PE);
  localparam int CFW   = (CF_W > 0) ? CF_W : 1;
  localparam int PEW   = (PE_W > 0) ? PE_W : 1;
  localparam int RC_W  = $clog2(TOTAL + 1);
  localparam int CHK_W = K + RC_W;

  typedef enum logic [1:0] {S_LOAD, S_READ, S_DRAIN, S_DONE} state_t;

  state_t          state, state_next;
  logic [N-1:0]    t_cnt;
  logic [PEW-1:0]  pe_cnt;
  logic [CFW-1:0]  cf_cnt;
  logic [N-1:0]    rt_cnt;
  logic [RC_W-1:0] rack_cnt;
  logic [CHK_W-1:0] chk_w, chk_r;
  logic [K-1:0]    prev_w, prev_r;
  logic [A_W-1:0]  cur_a;
  logic            accept, issue_rd, last_addr, rack_ok, last_rack;
  logic            rearm, stray_rack, ord_bad_w, ord_bad_r;

  assign state_dbg = state;

  // "a <= b" in the configured signedness; a hit means the sequence is not strictly ascending
  function automatic logic le_cmp(input logic [K-1:0] a, input logic [K-1:0] b);
    if (SIGNED) le_cmp = ($signed(a) <= $signed(b));
    else        le_cmp = (a <= b);
  endfunction

  // Pack {cf, pe, t}; fields of zero width are simply left out
  always_comb begin
    cur_a = A_W'(t_cnt);
    if (PE_W > 0) cur_a = cur_a | (A_W'(pe_cnt) << N);
    if (CF_W > 0) cur_a = cur_a | (A_W'(cf_cnt) << (N + PE_W));
  end

  // Next-state logic and per-cycle strobes
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue_rd   = 1'b0;
    rearm      = 1'b0;
    last_addr  = (t_cnt == N'(T_MAX)) && (pe_cnt == PEW'(PE - 1)) && (cf_cnt == CFW'(CF - 1));
    rack_ok    = cfg_rack && ((state == S_READ) || (state == S_DRAIN));
    last_rack  = cfg_rack && (state == S_DRAIN) && (rack_cnt == RC_W'(TOTAL - 1));
    case (state)
      S_LOAD: begin
        accept = s_tvalid && s_tready;
        if (accept && last_addr) state_next = VERIFY ? S_READ : S_DONE;
      end
      S_READ: begin
        issue_rd = 1'b1;
        if (last_addr) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_rack) state_next = S_DONE;
      end
      default: begin
        if (start) begin
          rearm      = 1'b1;
          state_next = S_LOAD;
        end
      end
    endcase
    // start in DONE wins over a coincident stray rack
    stray_rack = cfg_rack && ((state == S_LOAD) || ((state == S_DONE) && !start));
    ord_bad_w  = accept && (t_cnt != '0) && le_cmp(s_tdata, prev_w);
    ord_bad_r  = rack_ok && (rt_cnt != '0) && le_cmp(cfg_q, prev_r);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_next;
  end

  // Address counters, shared by the write pass and the read pass; they wrap to zero after the last address
  always_ff @(posedge clk) begin
    if (!rst_n || rearm) begin
      t_cnt  <= '0;
      pe_cnt <= '0;
      cf_cnt <= '0;
    end else if (accept || issue_rd) begin
      if (t_cnt == N'(T_MAX)) begin
        t_cnt <= '0;
        if (pe_cnt == PEW'(PE - 1)) begin
          pe_cnt <= '0;
          if (cf_cnt == CFW'(CF - 1)) cf_cnt <= '0;
          else                        cf_cnt <= cf_cnt + 1'b1;
        end else begin
          pe_cnt <= pe_cnt + 1'b1;
        end
      end else begin
        t_cnt <= t_cnt + 1'b1;
      end
    end
  end

  // Write-side checksum and previous-value tracking
  always_ff @(posedge clk) begin
    if (!rst_n || rearm) begin
      chk_w  <= '0;
      prev_w <= '0;
    end else if (accept) begin
      chk_w  <= chk_w + CHK_W'(s_tdata);
      prev_w <= s_tdata;
    end
  end

  // Readback accounting: rack count, threshold index within channel, checksum, previous value
  always_ff @(posedge clk) begin
    if (!rst_n || rearm) begin
      rt_cnt   <= '0;
      rack_cnt <= '0;
      chk_r    <= '0;
      prev_r   <= '0;
    end else if (rack_ok) begin
      rt_cnt   <= (rt_cnt == N'(T_MAX)) ? '0 : rt_cnt + 1'b1;
      rack_cnt <= rack_cnt + 1'b1;
      chk_r    <= chk_r + CHK_W'(cfg_q);
      prev_r   <= cfg_q;
    end
  end

  // Registered config port, stream ready and done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_tready <= 1'b0;
      cfg_en   <= 1'b0;
      cfg_we   <= 1'b0;
      cfg_a    <= '0;
      cfg_d    <= '0;
      done     <= 1'b0;
    end else begin
      s_tready <= (state_next == S_LOAD);
      cfg_en   <= accept || issue_rd;
      if (accept) begin
        cfg_we <= 1'b1;
        cfg_a  <= cur_a;
        cfg_d  <= s_tdata;
      end else if (issue_rd) begin
        cfg_we <= 1'b0;
        cfg_a  <= cur_a;
        cfg_d  <= '0;
      end
      // Without readback, done waits one extra cycle so it follows the last write on cfg_*
      done <= (state_next == S_DONE) && (VERIFY || (state == S_DONE));
    end
  end

  // Sticky error flags, cleared by reset or re-arm
  always_ff @(posedge clk) begin
    if (!rst_n || rearm) begin
      err_order <= 1'b0;
      err_chk   <= 1'b0;
    end else begin
      if (ord_bad_w) err_order <= 1'b1;
      if (ord_bad_r || stray_rack || (last_rack && ((chk_r + CHK_W'(cfg_q)) != chk_w)))
        err_chk <= 1'b1;
    end
  end

endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// Directed testbench for thresholding_cfg_loader (N=2, K=8, C=2, PE=2).
// Two instances share the stream: u_dut (VERIFY=1) with a target model, and
// u_dut_nv (VERIFY=0) used for the no-readback done timing.
module tb_thresholding_cfg_loader;

  localparam int K   = 8;
  localparam int A_W = 3;

  // ---------------- clock / reset / signals ----------------
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_tvalid = 1'b0;
  logic [K-1:0]   s_tdata = '0;
  logic           start = 1'b0;
  logic           corrupt = 1'b0;
  logic           stray = 1'b0;

  logic           s_tready, cfg_en, cfg_we, cfg_rack, done, err_order, err_chk;
  logic [A_W-1:0] cfg_a;
  logic [K-1:0]   cfg_d, cfg_q;
  logic [1:0]     state_dbg;

  logic           s_tready_nv, cfg_en_nv, cfg_we_nv, done_nv, err_order_nv, err_chk_nv;
  logic [A_W-1:0] cfg_a_nv;
  logic [K-1:0]   cfg_d_nv;
  logic [1:0]     state_dbg_nv;

  always #5 clk = ~clk;

  thresholding_cfg_loader #(.N(2), .K(8), .C(2), .PE(2), .SIGNED(1'b1), .VERIFY(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_a(cfg_a), .cfg_d(cfg_d),
    .cfg_rack(cfg_rack), .cfg_q(cfg_q), .start(start), .done(done),
    .err_order(err_order), .err_chk(err_chk), .state_dbg(state_dbg)
  );

  thresholding_cfg_loader #(.N(2), .K(8), .C(2), .PE(2), .SIGNED(1'b1), .VERIFY(1'b0)) u_dut_nv (
    .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(s_tready_nv), .s_tdata(s_tdata),
    .cfg_en(cfg_en_nv), .cfg_we(cfg_we_nv), .cfg_a(cfg_a_nv), .cfg_d(cfg_d_nv),
    .cfg_rack(1'b0), .cfg_q(8'h00), .start(start), .done(done_nv),
    .err_order(err_order_nv), .err_chk(err_chk_nv), .state_dbg(state_dbg_nv)
  );

  // ---------------- target model: table memory, one-cycle readback ----------------
  logic [K-1:0] tgt_mem [0:7];
  logic         rack_q;
  logic [K-1:0] q_q;

  always @(posedge clk) begin
    if (!rst_n) rack_q <= 1'b0;
    else        rack_q <= cfg_en && !cfg_we;
    if (cfg_en && cfg_we) tgt_mem[cfg_a] <= cfg_d;
    q_q <= tgt_mem[cfg_a] ^ ((corrupt && (cfg_a == 3'd5)) ? 8'h01 : 8'h00);
  end

  assign cfg_rack = rack_q | stray;
  assign cfg_q    = q_q;

  // ---------------- bus logs ----------------
  logic [A_W-1:0] wr_a_log[$];
  logic [K-1:0]   wr_d_log[$];
  logic [A_W-1:0] rd_a_log[$];
  logic [A_W-1:0] nv_a_log[$];
  int             nv_en_cnt = 0;

  always @(negedge clk) begin
    if (cfg_en && cfg_we) begin
      wr_a_log.push_back(cfg_a);
      wr_d_log.push_back(cfg_d);
    end
    if (cfg_en && !cfg_we) rd_a_log.push_back(cfg_a);
    if (cfg_en_nv) begin
      nv_en_cnt++;
      nv_a_log.push_back(cfg_a_nv);
    end
  end

  // ---------------- expected data and counters ----------------
  logic [K-1:0]   exp_q[$];
  logic [A_W-1:0] exp_a [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
  int errors = 0;
  int checks = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_a_log.delete();
    wr_d_log.delete();
    rd_a_log.delete();
    nv_a_log.delete();
    nv_en_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic send_beat(input logic [K-1:0] v);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = v;
    while (!s_tready && n < 50) begin
      tick();
      n++;
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_tready=%0b after %0d cycles, required 1", s_tready, n);
    end
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic send_exp();
    for (int i = 0; i < 6; i++) send_beat(exp_q[i]);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %0b required 0", s_tready); end
    checks++; if (cfg_en !== 1'b0 || cfg_we !== 1'b0) begin errors++; $display("FAIL rst_cfg_en_we: got %0b%0b required 00", cfg_en, cfg_we); end
    checks++; if (cfg_a !== 3'd0 || cfg_d !== 8'd0) begin errors++; $display("FAIL rst_cfg_a_d: got %0h/%0h required 0/0", cfg_a, cfg_d); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b required 0", done); end
    checks++; if (err_order !== 1'b0 || err_chk !== 1'b0) begin errors++; $display("FAIL rst_err: got %0b%0b required 00", err_order, err_chk); end
    rst_n = 1'b1;
    tick();
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL rst_release_tready: got %0b required 1", s_tready); end
  endtask

  task automatic test_basic();
    int n;
    clear_logs();
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd10, 8'd20, 8'd30};
    send_exp();
    checks++; if (cfg_en !== 1'b1 || cfg_we !== 1'b1 || cfg_a !== 3'd6 || cfg_d !== 8'd30) begin
      errors++; $display("FAIL basic_last_write: en=%0b we=%0b a=%0d d=%0d required 1 1 6 30", cfg_en, cfg_we, cfg_a, cfg_d); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL basic_tready_drop: got %0b required 0", s_tready); end
    checks++; if (done_nv !== 1'b0) begin errors++; $display("FAIL nv_done_early: got %0b required 0", done_nv); end
    tick();
    checks++; if (cfg_en !== 1'b1 || cfg_we !== 1'b0 || cfg_a !== 3'd0 || cfg_d !== 8'd0) begin
      errors++; $display("FAIL basic_first_read: en=%0b we=%0b a=%0d d=%0d required 1 0 0 0", cfg_en, cfg_we, cfg_a, cfg_d); end
    checks++; if (done_nv !== 1'b1) begin errors++; $display("FAIL nv_done: got %0b required 1", done_nv); end
    wait_done(n);
    checks++; if (n !== 7) begin errors++; $display("FAIL basic_done_latency: got %0d further cycles required 7", n); end
    checks++; if (done !== 1'b1 || err_order !== 1'b0 || err_chk !== 1'b0) begin
      errors++; $display("FAIL basic_result: done=%0b eo=%0b ec=%0b required 1 0 0", done, err_order, err_chk); end
    checks++; if (wr_a_log.size() !== 6 || rd_a_log.size() !== 6) begin
      errors++; $display("FAIL basic_counts: writes=%0d reads=%0d required 6 6", wr_a_log.size(), rd_a_log.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (wr_a_log[i] !== exp_a[i] || wr_d_log[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_write[%0d]: a=%0d d=%0d required a=%0d d=%0d", i, wr_a_log[i], wr_d_log[i], exp_a[i], exp_q[i]); end
      checks++; if (rd_a_log[i] !== exp_a[i]) begin
        errors++; $display("FAIL basic_read[%0d]: a=%0d required %0d", i, rd_a_log[i], exp_a[i]); end
    end
    checks++; if (cfg_en !== 1'b0) begin errors++; $display("FAIL basic_done_en: got %0b required 0", cfg_en); end
  endtask

  task automatic test_signed_and_rearm();
    int n;
    pulse_start();
    clear_logs();
    checks++; if (s_tready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL start_rearm: tready=%0b done=%0b required 1 0", s_tready, done); end
    // channel 0: -5, -6, 0 ; channel 1: 1, 2, 3
    exp_q = '{8'hFB, 8'hFA, 8'h00, 8'h01, 8'h02, 8'h03};
    send_beat(exp_q[0]);
    checks++; if (err_order !== 1'b0) begin errors++; $display("FAIL signed_first_beat: err_order=%0b required 0", err_order); end
    send_beat(exp_q[1]);
    checks++; if (err_order !== 1'b1) begin errors++; $display("FAIL signed_second_beat: err_order=%0b required 1", err_order); end
    for (int i = 2; i < 6; i++) send_beat(exp_q[i]);
    wait_done(n);
    checks++; if (done !== 1'b1 || err_order !== 1'b1) begin errors++; $display("FAIL signed_sticky: done=%0b eo=%0b required 1 1", done, err_order); end
    // the readback re-checks ordering, so the same descent also shows up there
    checks++; if (err_chk !== 1'b1) begin errors++; $display("FAIL signed_readback_order: err_chk=%0b required 1", err_chk); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (wr_d_log[i] !== exp_q[i]) begin errors++; $display("FAIL signed_write[%0d]: d=%0h required %0h", i, wr_d_log[i], exp_q[i]); end
    end
    // re-arm with both flags set
    pulse_start();
    clear_logs();
    checks++; if (err_order !== 1'b0 || err_chk !== 1'b0 || done !== 1'b0 || s_tready !== 1'b1) begin
      errors++; $display("FAIL rearm_clear: eo=%0b ec=%0b done=%0b tready=%0b required 0 0 0 1", err_order, err_chk, done, s_tready); end
    // channel 1 starts below channel 0's last value (no cross-channel compare); -3 < 4 only when signed
    exp_q = '{8'd50, 8'd60, 8'd70, 8'hFD, 8'h04, 8'h07};
    send_exp();
    wait_done(n);
    checks++; if (done !== 1'b1 || err_order !== 1'b0 || err_chk !== 1'b0) begin
      errors++; $display("FAIL rearm_second_load: done=%0b eo=%0b ec=%0b required 1 0 0", done, err_order, err_chk); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (wr_a_log[i] !== exp_a[i] || wr_d_log[i] !== exp_q[i]) begin
        errors++; $display("FAIL rearm_write[%0d]: a=%0d d=%0h required a=%0d d=%0h", i, wr_a_log[i], wr_d_log[i], exp_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_corrupt();
    int n;
    pulse_start();
    corrupt = 1'b1;
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd10, 8'd20, 8'd30};
    send_exp();
    wait_done(n);
    corrupt = 1'b0;
    checks++; if (done !== 1'b1 || err_chk !== 1'b1 || err_order !== 1'b0) begin
      errors++; $display("FAIL corrupt_result: done=%0b ec=%0b eo=%0b required 1 1 0", done, err_chk, err_order); end
  endtask

  task automatic test_stray();
    int n;
    pulse_start();
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd10, 8'd20, 8'd30};
    send_exp();
    wait_done(n);
    checks++; if (err_chk !== 1'b0) begin errors++; $display("FAIL stray_clean_load: err_chk=%0b required 0", err_chk); end
    stray = 1'b1;
    tick();
    stray = 1'b0;
    checks++; if (err_chk !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL stray_in_done: ec=%0b done=%0b required 1 1", err_chk, done); end
    start = 1'b1;
    stray = 1'b1;
    tick();
    start = 1'b0;
    stray = 1'b0;
    checks++; if (err_chk !== 1'b0 || s_tready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL stray_start_wins: ec=%0b tready=%0b done=%0b required 0 1 0", err_chk, s_tready, done); end
  endtask

  task automatic test_bubbles();
    int n;
    clear_logs();
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd10, 8'd20, 8'd30};
    for (int i = 0; i < 6; i++) begin
      send_beat(exp_q[i]);
      if (i < 5) tick();
    end
    checks++; if (done_nv !== 1'b0) begin errors++; $display("FAIL bubble_nv_done_early: got %0b required 0", done_nv); end
    tick();
    checks++; if (done_nv !== 1'b1) begin errors++; $display("FAIL bubble_nv_done: got %0b required 1", done_nv); end
    checks++; if (nv_en_cnt !== 6) begin errors++; $display("FAIL bubble_en_pulses: got %0d required 6", nv_en_cnt); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (nv_a_log[i] !== exp_a[i]) begin errors++; $display("FAIL bubble_addr[%0d]: got %0d required %0d", i, nv_a_log[i], exp_a[i]); end
    end
    wait_done(n);
    checks++; if (done !== 1'b1 || err_chk !== 1'b0 || err_order !== 1'b0) begin
      errors++; $display("FAIL bubble_verify: done=%0b ec=%0b eo=%0b required 1 0 0", done, err_chk, err_order); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    pulse_start();
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd10, 8'd20, 8'd30};
    send_exp();
    tick();
    tick();
    tick();
    checks++; if (cfg_en !== 1'b1 || cfg_we !== 1'b0 || cfg_a !== 3'd2) begin
      errors++; $display("FAIL midread_third_read: en=%0b we=%0b a=%0d required 1 0 2", cfg_en, cfg_we, cfg_a); end
    rst_n = 1'b0;
    tick();
    checks++; if (s_tready !== 1'b0 || cfg_en !== 1'b0 || cfg_we !== 1'b0 || cfg_a !== 3'd0 || cfg_d !== 8'd0) begin
      errors++; $display("FAIL midread_reset_outputs: tready=%0b en=%0b we=%0b a=%0d d=%0d required 0 0 0 0 0", s_tready, cfg_en, cfg_we, cfg_a, cfg_d); end
    checks++; if (done !== 1'b0 || err_order !== 1'b0 || err_chk !== 1'b0) begin
      errors++; $display("FAIL midread_reset_flags: done=%0b eo=%0b ec=%0b required 0 0 0", done, err_order, err_chk); end
    rst_n = 1'b1;
    tick();
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL midread_release_tready: got %0b required 1", s_tready); end
    clear_logs();
    exp_q = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd11};
    send_exp();
    wait_done(n);
    checks++; if (done !== 1'b1 || err_order !== 1'b0 || err_chk !== 1'b0) begin
      errors++; $display("FAIL midread_reload: done=%0b eo=%0b ec=%0b required 1 0 0", done, err_order, err_chk); end
    checks++; if (wr_a_log.size() !== 6 || rd_a_log.size() !== 6) begin
      errors++; $display("FAIL midread_counts: writes=%0d reads=%0d required 6 6", wr_a_log.size(), rd_a_log.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_signed_and_rearm();
    test_corrupt();
    test_stray();
    test_bubbles();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule
